// File: rtl/eth_bus_arbiter_pkg.sv
// eth_bus_arbiter_pkg: state encodings and owner constants shared with the bus-mux top level
package eth_bus_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        TURN   = 2'd3
    } arb_state_t;
    localparam logic OWNER0 = 1'b0;
    localparam logic OWNER1 = 1'b1;
endpackage

// File: rtl/eth_bus_arbiter_arb_cycle_counter.sv
// arb_cycle_counter: saturating up-counter with clear, enable and terminal-count flag
module arb_cycle_counter #(
    parameter int W = 4
) (
    input  logic         sysclk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc,
    output logic         done
);
    logic [W-1:0] cnt;
    always_ff @(posedge sysclk) begin
        if (!reset || clr) cnt <= '0;
        else if (en && cnt != '1) cnt <= cnt + 1'b1;
    end
    assign done = cnt == tc;
endmodule

// File: rtl/eth_bus_arbiter.sv
// eth_bus_arbiter: two-requester round-robin bus arbiter with turnaround dead cycles
// Optional grant timeout enabled by defining ETH_ARB_TIMEOUT_EN.
module eth_bus_arbiter
    import eth_bus_arbiter_pkg::*;
#(
    parameter int TURN_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic sysclk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic sel,
    output logic bus_busy,
    output logic timeout_err
);
    if (TURN_CYCLES < 0 || TURN_CYCLES > 15) $error("TURN_CYCLES out of range");
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) $error("TIMEOUT_CYCLES out of range");
    localparam arb_state_t REL = (TURN_CYCLES == 0) ? IDLE : TURN;
    arb_state_t state, nxt;
    logic last_owner, lo_nxt, turn_done, to_fire, req0_e, req1_e;
    arb_cycle_counter #(.W(4)) u_turn (
        .sysclk(sysclk),
        .reset (reset),
        .clr   (state != TURN),
        .en    (state == TURN),
        .tc    (4'(TURN_CYCLES - 1)),
        .done  (turn_done)
    );
`ifdef ETH_ARB_TIMEOUT_EN
    logic to_done, mask0, mask1;
    arb_cycle_counter #(.W(8)) u_tmo (
        .sysclk(sysclk),
        .reset (reset),
        .clr   (state != GRANT0 && state != GRANT1),
        .en    (1'b1),
        .tc    (8'(TIMEOUT_CYCLES - 1)),
        .done  (to_done)
    );
    assign to_fire = to_done && (state == GRANT0 ? req0 : (state == GRANT1 && req1));
    assign req0_e  = req0 && !mask0;
    assign req1_e  = req1 && !mask1;
    // a timed-out requester stays masked until it has let go of its request once
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            mask0 <= 1'b0;
            mask1 <= 1'b0;
        end else begin
            mask0 <= req0 && (mask0 || (to_fire && state == GRANT0));
            mask1 <= req1 && (mask1 || (to_fire && state == GRANT1));
        end
    end
`else
    assign to_fire = 1'b0;
    assign req0_e  = req0;
    assign req1_e  = req1;
`endif
    always_comb begin
        nxt    = state;
        lo_nxt = last_owner;
        case (state)
            IDLE:   nxt = (req0_e && req1_e) ? (last_owner ? GRANT0 : GRANT1) :
                          req0_e ? GRANT0 : req1_e ? GRANT1 : IDLE;
            GRANT0: if (!req0 || to_fire) begin
                nxt    = REL;
                lo_nxt = OWNER0;
            end
            GRANT1: if (!req1 || to_fire) begin
                nxt    = REL;
                lo_nxt = OWNER1;
            end
            default: nxt = turn_done ? IDLE : TURN;
        endcase
    end
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state       <= IDLE;
            last_owner  <= OWNER1;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            sel         <= 1'b0;
            bus_busy    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= nxt;
            last_owner  <= lo_nxt;
            gnt0        <= nxt == GRANT0;
            gnt1        <= nxt == GRANT1;
            sel         <= (nxt == GRANT0) ? OWNER0 : (nxt == GRANT1) ? OWNER1 : sel;
            bus_busy    <= nxt != IDLE;
            timeout_err <= to_fire;
        end
    end
endmodule

// File: tb/tb_eth_bus_arbiter.sv
// tb_eth_bus_arbiter: directed self-checking bench for eth_bus_arbiter
module tb_eth_bus_arbiter;
    logic sysclk = 1'b0;
    logic reset, req0, req1;
    logic gnt0, gnt1, sel, bus_busy, timeout_err;
    int   n_cmp = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;
    logic prev_g = 1'b0;
    logic prev_sel = 1'b0;
    logic owner;

    always #5 sysclk = ~sysclk;

    eth_bus_arbiter #(
        .TURN_CYCLES(1),
`ifdef ETH_ARB_TIMEOUT_EN
        .TIMEOUT_CYCLES(8)
`else
        .TIMEOUT_CYCLES(255)
`endif
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .sel        (sel),
        .bus_busy   (bus_busy),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // exclusive grants and a stable select while the bus is owned
    always @(negedge sysclk) begin
        if (mon_en) begin
            chk("mutex", {7'd0, gnt0 & gnt1}, 8'd0);
            if (prev_g && (gnt0 || gnt1)) chk("sel_hold", {7'd0, sel}, {7'd0, prev_sel});
            prev_g   = gnt0 | gnt1;
            prev_sel = sel;
        end
    end

    initial begin
        reset = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        step(1);
        mon_en = 1'b1;
        chk("rst_gnt", {6'd0, gnt1, gnt0}, 8'd0);
        chk("rst_sel", {7'd0, sel}, 8'd0);
        chk("rst_busy", {7'd0, bus_busy}, 8'd0);
        step(1);
        chk("rst2_gnt", {6'd0, gnt1, gnt0}, 8'd0);
        chk("rst2_busy", {7'd0, bus_busy}, 8'd0);
        chk("rst_toerr", {7'd0, timeout_err}, 8'd0);
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        step(1);
        chk("idle_busy", {7'd0, bus_busy}, 8'd0);

        req1 = 1'b1;
        step(1);
        chk("single_gnt", {6'd0, gnt1, gnt0}, 8'd2);
        chk("single_sel", {7'd0, sel}, 8'd1);
        chk("single_busy", {7'd0, bus_busy}, 8'd1);
        step(8);
        chk("single_hold", {6'd0, gnt1, gnt0}, 8'd2);
        req1 = 1'b0;
        step(1);
        chk("single_rel", {6'd0, gnt1, gnt0}, 8'd0);
        chk("turn_sel", {7'd0, sel}, 8'd1);
        chk("turn_busy", {7'd0, bus_busy}, 8'd1);
        step(1);
        chk("after_busy", {7'd0, bus_busy}, 8'd0);
        chk("idle_sel", {7'd0, sel}, 8'd1);

        reset = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        step(1);
        reset = 1'b1;
        step(1);
        chk("tie_first", {6'd0, gnt1, gnt0}, 8'd1);
        chk("tie_sel", {7'd0, sel}, 8'd0);
        owner = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(2);
            if (owner) req1 = 1'b0;
            else req0 = 1'b0;
            step(1);
            chk("rr_turn", {6'd0, gnt1, gnt0}, 8'd0);
            chk("rr_turn_sel", {7'd0, sel}, {7'd0, owner});
            req0 = 1'b1;
            req1 = 1'b1;
            step(1);
            chk("rr_idle", {6'd0, gnt1, gnt0}, 8'd0);
            step(1);
            owner = ~owner;
            chk("rr_gnt", {6'd0, gnt1, gnt0}, owner ? 8'd2 : 8'd1);
            chk("rr_sel", {7'd0, sel}, {7'd0, owner});
        end
        req0 = 1'b0;
        req1 = 1'b0;
        step(2);

        req0 = 1'b1;
        step(1);
        chk("np_gnt0", {6'd0, gnt1, gnt0}, 8'd1);
        req1 = 1'b1;
        step(3);
        chk("np_nopre", {6'd0, gnt1, gnt0}, 8'd1);
        req0 = 1'b0;
        step(1);
        chk("np_turn", {6'd0, gnt1, gnt0}, 8'd0);
        step(1);
        chk("np_idle", {6'd0, gnt1, gnt0}, 8'd0);
        step(1);
        chk("np_gnt1", {6'd0, gnt1, gnt0}, 8'd2);
        chk("np_sel", {7'd0, sel}, 8'd1);

        step(1);
        reset = 1'b0;
        step(1);
        chk("mid_rst_gnt", {6'd0, gnt1, gnt0}, 8'd0);
        chk("mid_rst_sel", {7'd0, sel}, 8'd0);
        chk("mid_rst_busy", {7'd0, bus_busy}, 8'd0);
        reset = 1'b1;
        req0  = 1'b1;
        step(1);
        chk("mid_rst_tie", {6'd0, gnt1, gnt0}, 8'd1);

        req0 = 1'b0;
        req1 = 1'b0;
        step(1);
        req1 = 1'b1;
        step(1);
        req1 = 1'b0;
        step(1);
        chk("withdraw_gnt", {6'd0, gnt1, gnt0}, 8'd0);
        chk("withdraw_busy", {7'd0, bus_busy}, 8'd0);

`ifdef ETH_ARB_TIMEOUT_EN
        req0 = 1'b1;
        step(1);
        chk("to_gnt0", {6'd0, gnt1, gnt0}, 8'd1);
        req1 = 1'b1;
        step(7);
        chk("to_hold", {6'd0, gnt1, gnt0}, 8'd1);
        chk("to_noerr", {7'd0, timeout_err}, 8'd0);
        step(1);
        chk("to_drop", {6'd0, gnt1, gnt0}, 8'd0);
        chk("to_err", {7'd0, timeout_err}, 8'd1);
        step(1);
        chk("to_pulse", {7'd0, timeout_err}, 8'd0);
        step(1);
        chk("to_serve1", {6'd0, gnt1, gnt0}, 8'd2);
        req1 = 1'b0;
        step(3);
        chk("to_masked", {6'd0, gnt1, gnt0}, 8'd0);
        chk("to_masked_busy", {7'd0, bus_busy}, 8'd0);
        req0 = 1'b0;
        step(1);
        req0 = 1'b1;
        step(1);
        chk("to_regrant", {6'd0, gnt1, gnt0}, 8'd1);
        req0 = 1'b0;
        step(2);
`else
        req0 = 1'b1;
        step(20);
        chk("long_gnt0", {6'd0, gnt1, gnt0}, 8'd1);
        chk("long_toerr", {7'd0, timeout_err}, 8'd0);
        req0 = 1'b0;
        step(2);
`endif
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
